// File: rtl/bus_demux4_pkg.sv
// Shared definitions for the four-target data-port bus demultiplexer.
package bus_demux4_pkg;

  // Transaction phases: waiting for a request, waiting for the target, completing.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } state_e;

  // Target indices, selected by the top two address bits.
  localparam logic [1:0] TgtRam   = 2'd0;
  localparam logic [1:0] TgtIo    = 2'd1;
  localparam logic [1:0] TgtTimer = 2'd2;
  localparam logic [1:0] TgtDebug = 2'd3;

  localparam int unsigned DefaultTimeout = 15;
  localparam int unsigned CtrW           = 8;

  // One-hot request vector for a target index.
  function automatic logic [3:0] tgt_onehot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// BUSY-cycle counter: cleared on request accept, expires at Timeout-1 and never wraps.
module bus_timeout_ctr
  import bus_demux4_pkg::*;
#(
  parameter int unsigned Timeout = DefaultTimeout
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [CtrW-1:0] Last = CtrW'(Timeout - 1);

  logic [CtrW-1:0] cnt_q, cnt_d;

  // Next count: clear wins over increment; hold otherwise.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == Last);

endmodule

// File: rtl/bus_demux4.sv
// Routes one initiator request at a time to one of four targets by address region,
// waits for that target's ack (or a timeout) and returns data/error to the initiator.
module bus_demux4
  import bus_demux4_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m_req,
  input  logic                m_we,
  input  logic [ADDR_W-1:0]   m_addr,
  input  logic [DATA_W-1:0]   m_wdata,
  input  logic [3:0]          m_wstrb,
  output logic                m_ready,
  output logic                m_rvalid,
  output logic [DATA_W-1:0]   m_rdata,
  output logic                m_err,
  output logic [3:0]          s_req,
  output logic                s_we,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [3:0]          s_wstrb,
  input  logic [3:0]          s_ack,
  input  logic [4*DATA_W-1:0] s_rdata
);

  state_e            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [3:0]        s_req_q, s_req_d;
  logic              s_we_q, s_we_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
  logic [3:0]        s_wstrb_q, s_wstrb_d;
  logic              m_rvalid_q, m_rvalid_d;
  logic [DATA_W-1:0] m_rdata_q, m_rdata_d;
  logic              m_err_q, m_err_d;
  logic              ctr_clr, ctr_en, ctr_expire;

  bus_timeout_ctr #(
    .Timeout (TIMEOUT)
  ) u_timeout_ctr (
    .clk_i    (clk),
    .rst_i    (rst),
    .clr_i    (ctr_clr),
    .en_i     (ctr_en),
    .expire_o (ctr_expire)
  );

  // Next-state and registered-output logic; only the selected target's ack counts.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    s_req_d    = s_req_q;
    s_we_d     = s_we_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    s_wstrb_d  = s_wstrb_q;
    m_rvalid_d = 1'b0;
    m_rdata_d  = m_rdata_q;
    m_err_d    = m_err_q;
    ctr_clr    = 1'b0;
    ctr_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (m_req) begin
          sel_d     = m_addr[ADDR_W-1 -: 2];
          s_req_d   = tgt_onehot(m_addr[ADDR_W-1 -: 2]);
          s_we_d    = m_we;
          s_addr_d  = m_addr;
          s_wdata_d = m_wdata;
          s_wstrb_d = m_wstrb;
          ctr_clr   = 1'b1;
          state_d   = StBusy;
        end
      end
      StBusy: begin
        // Ack beats a simultaneous timeout.
        if (s_ack[sel_q]) begin
          m_rdata_d  = s_we_q ? '0 : s_rdata[int'(sel_q)*DATA_W +: DATA_W];
          m_err_d    = 1'b0;
          m_rvalid_d = 1'b1;
          s_req_d    = '0;
          state_d    = StResp;
        end else if (ctr_expire) begin
          m_rdata_d  = '0;
          m_err_d    = 1'b1;
          m_rvalid_d = 1'b1;
          s_req_d    = '0;
          state_d    = StResp;
        end else begin
          ctr_en = 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        s_req_d = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      sel_q      <= TgtRam;
      s_req_q    <= '0;
      s_we_q     <= 1'b0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      s_wstrb_q  <= '0;
      m_rvalid_q <= 1'b0;
      m_rdata_q  <= '0;
      m_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      s_req_q    <= s_req_d;
      s_we_q     <= s_we_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      s_wstrb_q  <= s_wstrb_d;
      m_rvalid_q <= m_rvalid_d;
      m_rdata_q  <= m_rdata_d;
      m_err_q    <= m_err_d;
    end
  end

  assign m_ready  = (state_q == StIdle);
  assign m_rvalid = m_rvalid_q;
  assign m_rdata  = m_rdata_q;
  assign m_err    = m_err_q;
  assign s_req    = s_req_q;
  assign s_we     = s_we_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign s_wstrb  = s_wstrb_q;

endmodule

// File: doc/bus_demux4.md
# bus_demux4

Single-initiator, four-target memory bus demultiplexer for the RV32 core's data port. It routes each load/store request to one of four targets (data RAM, I/O, timer, debug) by address region, holds the request until that target acknowledges, and steers the read data or error back to the core. It sits between the core's load/store unit and the peripheral slaves, the routing counterpart of the core's result-select muxes.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 15, cycles in BUSY without acknowledge before an error response (1..255)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- m_req  in  1  initiator request, sampled only while m_ready=1
- m_we  in  1  1=store, 0=load
- m_addr  in  ADDR_W  byte address
- m_wdata  in  DATA_W  store data
- m_wstrb  in  4  byte-lane enables
- m_ready  out  1  block can accept a request
- m_rvalid  out  1  one-cycle completion pulse (loads and stores)
- m_rdata  out  DATA_W  load data, valid with m_rvalid
- m_err  out  1  completion was a timeout, valid with m_rvalid
- s_req  out  4  one-hot target request
- s_we, s_addr, s_wdata, s_wstrb  out  1/ADDR_W/DATA_W/4  broadcast copies of the latched request
- s_ack  in  4  per-target acknowledge
- s_rdata  in  4*DATA_W  target read data, target i at bits [i*DATA_W +: DATA_W]

## Operation
- Target select sel = m_addr[ADDR_W-1:ADDR_W-2]; every address maps to exactly one target.
- States: IDLE, BUSY, RESP.
- IDLE: m_ready=1. On m_req=1, latch we/addr/wdata/wstrb and sel, clear timeout counter, go BUSY.
- BUSY: s_req[sel]=1, other bits 0; s_* buses show latched request. If s_ack[sel]=1: capture s_rdata slice sel into m_rdata (0 for stores), m_err<=0, go RESP. Else if counter = TIMEOUT-1: m_rdata<=0, m_err<=1, go RESP. Else counter+1.
- Acks on non-selected targets are ignored in every state; acks in IDLE/RESP ignored.
- RESP: m_rvalid=1 for exactly one cycle, s_req=0, go IDLE.
- m_req while not IDLE is not sampled; initiator must hold or re-issue.
- Counter width 8 bits; never wraps (leaves BUSY at TIMEOUT-1).
- Ack and timeout on the same cycle: ack wins, m_err=0.

## Timing
- All outputs registered except m_ready (decoded from state).
- Reset values: state IDLE, m_ready=1, s_req=0, s_we=0, s_addr=0, s_wdata=0, s_wstrb=0, m_rvalid=0, m_rdata=0, m_err=0, counter 0.
- Request accepted at edge 0 -> s_req visible after edge 0 -> ack sampled at edge k (k>=1) -> m_rvalid high for the cycle after edge k -> m_ready high again after edge k+1.
- Minimum turnaround: 3 cycles per transaction (zero-wait ack).
- Timeout: m_rvalid with m_err=1 in the cycle after TIMEOUT cycles in BUSY.
- rst mid-transaction: immediate return to reset values; pending s_req dropped, no m_rvalid.

## Structure
- Shared package: state encoding (IDLE/BUSY/RESP), target index constants (RAM=0, IO=1, TIMER=2, DEBUG=3), default TIMEOUT.
- One sub-module natural: bus_timeout_ctr (clear, enable, expire at TIMEOUT-1).

## Test plan
- Reset asserted mid-BUSY toward target 2 -> s_req=0, m_ready=1, no m_rvalid, all outputs at reset values.
- Load addr 0x4000_0010, target 1 acks next cycle with 0xDEAD_BEEF -> s_req=4'b0010 for one cycle, m_rvalid with m_rdata=0xDEAD_BEEF, m_err=0.
- Store addr 0xC000_0004, wdata 0x1234_5678, wstrb 4'b0011, ack after 5 cycles -> s_req=4'b1000 held 5 cycles, s_wdata/s_wstrb stable, m_rvalid with m_rdata=0, m_err=0.
- Load to target 0, never acked, TIMEOUT=15 -> m_rvalid after 15 BUSY cycles, m_err=1, m_rdata=0.
- Target 3 acks while target 0 selected, then target 0 acks -> first ack ignored, completion data from slice 0.
- m_req held high across transaction, back-to-back loads -> second accepted only in IDLE, 3-cycle spacing, ack on exact timeout cycle gives m_err=0.
